// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - CPU system-bus signals between initiator and memory responder
interface mem_bus_responder_if;
  logic        r_;
  logic        w_;
  logic        s_;
  logic        qb;
  logic [0:3]  nb;
  logic [0:15] ad;
  logic [0:15] dt_in;
  logic        ok_;
  logic        en_;
  logic [0:15] dt_out;
  logic        busy;

  modport master (
    output r_, w_, s_, qb, nb, ad, dt_in,
    input  ok_, en_, dt_out, busy
  );

  modport slave (
    input  r_, w_, s_, qb, nb, ad, dt_in,
    output ok_, en_, dt_out, busy
  );
endinterface

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory-side bus responder: NB:page frame map, word storage, OK/EN four-phase reply
module mem_bus_responder #(
  parameter int FRAMES = 4,
  parameter int LAT    = 2
) (
  input  logic               clk_sys,
  input  logic               rst,
  mem_bus_responder_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LATCH   = 3'd1;
  localparam logic [2:0] S_ACCESS  = 3'd2;
  localparam logic [2:0] S_RESP    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam int         ACC_CYC  = (LAT > 1) ? LAT - 1 : 1;
  localparam logic [3:0] ACC_LAST = 4'(ACC_CYC - 1);
  localparam logic [3:0] NFRAMES  = 4'(FRAMES);
  localparam int         MAW      = $clog2(FRAMES * 4096);

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic        armed;
  logic        ok_r;
  logic        en_r;
  logic        busy_r;
  logic [15:0] dt_r;

  // map entry = {valid, frame[2:0]}, indexed by {nb, page}
  logic [3:0]  map [0:255];
  logic [15:0] mem [0:FRAMES*4096-1];

  logic           cap_ok;
  logic           cap_rd;
  logic           cap_wr;
  logic           cap_map_we;
  logic [MAW-1:0] cap_phys;
  logic [15:0]    cap_dt;
  logic [7:0]     cap_map_idx;
  logic [3:0]     cap_map_val;

  logic [2:0] req_n;
  logic       all_high;
  logic       single;
  logic [3:0] page;
  logic [7:0] req_idx;
  logic [3:0] entry;
  logic       map_hit;
  logic [3:0] cfg_page;
  logic [2:0] cfg_frame;
  logic       cfg_valid;
  logic       cfg_locked;

  always_comb begin
    req_n      = {bus.r_, bus.w_, bus.s_};
    all_high   = &req_n;
    single     = (req_n == 3'b011) || (req_n == 3'b101) || (req_n == 3'b110);
    page       = bus.ad[0:3];
    req_idx    = {bus.nb, page};
    entry      = map[req_idx];
    map_hit    = entry[3] && ({1'b0, entry[2:0]} < NFRAMES);
    cfg_page   = bus.dt_in[0:3];
    cfg_frame  = bus.dt_in[4:6];
    cfg_valid  = bus.dt_in[7];
    // NB0 pages 0 and 1 are the boot mapping and cannot be remapped
    cfg_locked = (bus.nb == 4'd0) && (cfg_page[3:1] == 3'd0);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      armed  <= 1'b0;
      ok_r   <= 1'b1;
      en_r   <= 1'b1;
      busy_r <= 1'b0;
      dt_r   <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          // a new transaction needs one idle cycle with every request high
          if (armed && !all_high) begin
            state  <= S_LATCH;
            busy_r <= 1'b1;
            armed  <= 1'b0;
          end else begin
            armed <= all_high;
          end
        end
        S_LATCH: begin
          cap_rd      <= single && !bus.r_;
          cap_wr      <= single && !bus.w_;
          cap_ok      <= single && (bus.s_ ? map_hit : !bus.qb);
          cap_phys    <= MAW'({entry[2:0], bus.ad[4:15]});
          cap_dt      <= bus.dt_in;
          cap_map_idx <= {bus.nb, cfg_page};
          cap_map_val <= {cfg_valid && ({1'b0, cfg_frame} < NFRAMES), cfg_frame};
          cap_map_we  <= single && !bus.s_ && !bus.qb && !cfg_locked;
          cnt         <= 4'd0;
          state       <= S_ACCESS;
        end
        S_ACCESS: begin
          if (cnt == ACC_LAST) state <= S_RESP;
          else                 cnt   <= cnt + 4'd1;
        end
        S_RESP: begin
          ok_r  <= !cap_ok;
          en_r  <= cap_ok;
          dt_r  <= (cap_ok && cap_rd) ? mem[cap_phys] : 16'h0000;
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (all_high) begin
            ok_r   <= 1'b1;
            en_r   <= 1'b1;
            dt_r   <= 16'h0000;
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // storage survives rst; a write still pending when rst hits is dropped
  always_ff @(posedge clk_sys) begin
    if (!rst && state == S_RESP && cap_ok && cap_wr)
      mem[cap_phys] <= cap_dt;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) map[i] <= 4'h0;
      map[0] <= 4'b1000;
      map[1] <= 4'b1001;
    end else if (state == S_RESP && cap_map_we) begin
      map[cap_map_idx] <= cap_map_val;
    end
  end

  assign bus.ok_    = ok_r;
  assign bus.en_    = en_r;
  assign bus.dt_out = dt_r;
  assign bus.busy   = busy_r;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed table, reset-abort sequence and random traffic against a frame-map model
module tb_mem_bus_responder;
  localparam int FRAMES = 4;
  localparam int LAT    = 2;

  localparam logic [2:0] RD = 3'b011;
  localparam logic [2:0] WR = 3'b101;
  localparam logic [2:0] CF = 3'b110;

  logic clk_sys;
  logic rst;
  int   total;
  int   bad;

  mem_bus_responder_if bus ();

  mem_bus_responder #(.FRAMES(FRAMES), .LAT(LAT)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [2:0]  rws_n;
    logic        qb;
    logic [3:0]  nb;
    logic [15:0] ad;
    logic [15:0] dt;
    int          hold;
    logic        exp_ok;
    logic [15:0] exp_dt;
  } vec_t;

  vec_t vecs[$];

  // model: per-(nb,page) valid/frame and sparse storage keyed by physical word address
  bit          m_valid [256];
  bit [2:0]    m_frame [256];
  logic [15:0] m_mem   [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_frame[i] = 3'd0;
    end
    m_valid[0] = 1'b1;
    m_valid[1] = 1'b1;
    m_frame[1] = 3'd1;
  endtask

  task automatic model_apply(input logic [2:0] rws_n, input logic qb, input logic [3:0] nb,
                             input logic [15:0] ad, input logic [15:0] dt,
                             output logic exp_ok, output logic dt_known, output logic [15:0] exp_dt);
    int idx;
    int phys;
    int f;
    int p;
    exp_ok   = 1'b0;
    dt_known = 1'b1;
    exp_dt   = 16'h0000;
    if ($countones(rws_n) == 2) begin
      if (!rws_n[0]) begin
        if (!qb) begin
          exp_ok = 1'b1;
          p = int'(dt[15:12]);
          f = int'(dt[11:9]);
          if (!(nb == 4'd0 && p < 2)) begin
            idx = int'(nb) * 16 + p;
            m_valid[idx] = dt[8] && (f < FRAMES);
            m_frame[idx] = 3'(f);
          end
        end
      end else begin
        idx = int'(nb) * 16 + int'(ad[15:12]);
        if (m_valid[idx] && int'(m_frame[idx]) < FRAMES) begin
          exp_ok = 1'b1;
          phys = int'(m_frame[idx]) * 4096 + int'(ad[11:0]);
          if (!rws_n[1]) m_mem[phys] = dt;
          else if (m_mem.exists(phys)) exp_dt = m_mem[phys];
          else dt_known = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_bus();
    bus.r_ = 1'b1;
    bus.w_ = 1'b1;
    bus.s_ = 1'b1;
  endtask

  task automatic run_txn(input logic [2:0] rws_n, input logic qb, input logic [3:0] nb,
                         input logic [15:0] ad, input logic [15:0] dt, input int hold,
                         output logic g_ok, output logic g_en, output logic [15:0] g_dt,
                         output int g_lat, output logic g_held, output logic g_rel);
    @(negedge clk_sys);
    idle_bus();
    repeat (2) @(negedge clk_sys);
    {bus.r_, bus.w_, bus.s_} = rws_n;
    bus.qb    = qb;
    bus.nb    = nb;
    bus.ad    = ad;
    bus.dt_in = dt;
    @(posedge clk_sys);
    g_lat = 0;
    do begin
      @(posedge clk_sys);
      #1;
      g_lat++;
    end while (bus.ok_ && bus.en_ && g_lat < 40);
    g_ok   = bus.ok_;
    g_en   = bus.en_;
    g_dt   = bus.dt_out;
    g_held = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_sys);
      #1;
      if (bus.ok_ !== g_ok || bus.en_ !== g_en || bus.dt_out !== g_dt) g_held = 1'b0;
    end
    @(negedge clk_sys);
    idle_bus();
    @(posedge clk_sys);
    #1;
    g_rel = bus.ok_ && bus.en_ && (bus.dt_out == 16'h0000) && !bus.busy;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst = 1'b1;
    idle_bus();
    repeat (2) @(negedge clk_sys);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic txn_and_check(input string tag, input logic [2:0] rws_n, input logic qb,
                               input logic [3:0] nb, input logic [15:0] ad, input logic [15:0] dt,
                               input int hold, input logic exp_ok, input logic chk_dt,
                               input logic [15:0] exp_dt);
    logic g_ok, g_en, g_held, g_rel;
    logic [15:0] g_dt;
    int g_lat;
    run_txn(rws_n, qb, nb, ad, dt, hold, g_ok, g_en, g_dt, g_lat, g_held, g_rel);
    check({tag, " latency"}, 32'(g_lat), 32'(LAT + 1));
    check({tag, " ok_"}, 32'(g_ok), 32'(!exp_ok));
    check({tag, " en_"}, 32'(g_en), 32'(exp_ok));
    if (chk_dt) check({tag, " dt_out"}, 32'(g_dt), 32'(exp_dt));
    if (hold > 0) check({tag, " held"}, 32'(g_held), 32'd1);
    check({tag, " release"}, 32'(g_rel), 32'd1);
  endtask

  initial begin
    logic        m_ok, m_known;
    logic [15:0] m_dt;
    logic [2:0]  rws;
    logic        qb;
    logic [3:0]  nb;
    logic [15:0] ad, dt;
    int          k;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_bus();
    bus.qb    = 1'b0;
    bus.nb    = 4'd0;
    bus.ad    = 16'h0000;
    bus.dt_in = 16'h0000;

    vecs.push_back('{WR,    1'b0, 4'd0, 16'h1234, 16'hBEEF, 0,  1'b1, 16'h0000});
    vecs.push_back('{RD,    1'b0, 4'd0, 16'h1234, 16'h0000, 0,  1'b1, 16'hBEEF});
    vecs.push_back('{RD,    1'b0, 4'd3, 16'h5000, 16'h0000, 0,  1'b0, 16'h0000});
    vecs.push_back('{CF,    1'b0, 4'd3, 16'h0000, 16'h5500, 0,  1'b1, 16'h0000});
    vecs.push_back('{WR,    1'b0, 4'd3, 16'h5007, 16'hCAFE, 0,  1'b1, 16'h0000});
    vecs.push_back('{RD,    1'b0, 4'd3, 16'h5007, 16'h0000, 0,  1'b1, 16'hCAFE});
    vecs.push_back('{CF,    1'b1, 4'd3, 16'h0000, 16'h6500, 0,  1'b0, 16'h0000});
    vecs.push_back('{RD,    1'b0, 4'd3, 16'h6000, 16'h0000, 0,  1'b0, 16'h0000});
    vecs.push_back('{WR,    1'b0, 4'd0, 16'h0010, 16'h0A0A, 0,  1'b1, 16'h0000});
    vecs.push_back('{CF,    1'b0, 4'd3, 16'h0000, 16'h7700, 0,  1'b1, 16'h0000});
    vecs.push_back('{WR,    1'b0, 4'd3, 16'h7010, 16'h3333, 0,  1'b1, 16'h0000});
    vecs.push_back('{CF,    1'b0, 4'd0, 16'h0000, 16'h0700, 0,  1'b1, 16'h0000});
    vecs.push_back('{RD,    1'b0, 4'd0, 16'h0010, 16'h0000, 0,  1'b1, 16'h0A0A});
    vecs.push_back('{RD,    1'b0, 4'd3, 16'h7010, 16'h0000, 0,  1'b1, 16'h3333});
    vecs.push_back('{3'b001, 1'b0, 4'd0, 16'h0010, 16'hFFFF, 10, 1'b0, 16'h0000});
    vecs.push_back('{RD,    1'b0, 4'd0, 16'h0010, 16'h0000, 10, 1'b1, 16'h0A0A});
    vecs.push_back('{CF,    1'b0, 4'd3, 16'h0000, 16'h8F00, 0,  1'b1, 16'h0000});
    vecs.push_back('{RD,    1'b0, 4'd3, 16'h8000, 16'h0000, 0,  1'b0, 16'h0000});
    vecs.push_back('{3'b000, 1'b0, 4'd0, 16'h0010, 16'h1111, 0,  1'b0, 16'h0000});
    vecs.push_back('{WR,    1'b0, 4'd0, 16'h0050, 16'hAAAA, 0,  1'b1, 16'h0000});

    do_reset();
    #1;
    check("reset ok_", 32'(bus.ok_), 32'd1);
    check("reset en_", 32'(bus.en_), 32'd1);
    check("reset dt_out", 32'(bus.dt_out), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);

    foreach (vecs[i]) begin
      model_apply(vecs[i].rws_n, vecs[i].qb, vecs[i].nb, vecs[i].ad, vecs[i].dt, m_ok, m_known, m_dt);
      txn_and_check($sformatf("vec%0d", i), vecs[i].rws_n, vecs[i].qb, vecs[i].nb, vecs[i].ad,
                    vecs[i].dt, vecs[i].hold, vecs[i].exp_ok, 1'b1, vecs[i].exp_dt);
    end

    // rst lands while a write to NB0 0x0050 is in ACCESS
    @(negedge clk_sys);
    idle_bus();
    repeat (2) @(negedge clk_sys);
    {bus.r_, bus.w_, bus.s_} = WR;
    bus.qb    = 1'b0;
    bus.nb    = 4'd0;
    bus.ad    = 16'h0050;
    bus.dt_in = 16'h5555;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    check("abort busy before rst", 32'(bus.busy), 32'd1);
    @(negedge clk_sys);
    rst = 1'b1;
    @(posedge clk_sys);
    #1;
    check("abort ok_", 32'(bus.ok_), 32'd1);
    check("abort en_", 32'(bus.en_), 32'd1);
    check("abort busy", 32'(bus.busy), 32'd0);
    @(negedge clk_sys);
    rst = 1'b0;
    idle_bus();
    model_reset();
    txn_and_check("abort word", RD, 1'b0, 4'd0, 16'h0050, 16'h0000, 0, 1'b1, 1'b1, 16'hAAAA);
    txn_and_check("abort nb3 map", RD, 1'b0, 4'd3, 16'h5007, 16'h0000, 0, 1'b0, 1'b1, 16'h0000);
    txn_and_check("abort frame1", RD, 1'b0, 4'd0, 16'h1234, 16'h0000, 0, 1'b1, 1'b1, 16'hBEEF);

    for (int n = 0; n < 200; n++) begin
      k = int'($urandom_range(0, 9));
      if (k < 4)      rws = RD;
      else if (k < 7) rws = WR;
      else if (k < 9) rws = CF;
      else            rws = 3'($urandom_range(0, 6));
      qb = ($urandom_range(0, 3) == 0);
      k  = int'($urandom_range(0, 2));
      nb = (k == 0) ? 4'd0 : (k == 1) ? 4'd3 : 4'($urandom_range(0, 15));
      ad = {4'($urandom_range(0, 7)), 8'h00, 4'($urandom_range(0, 15))};
      dt = 16'($urandom);
      if (rws == CF) dt[15:12] = 4'($urandom_range(0, 7));
      model_apply(rws, qb, nb, ad, dt, m_ok, m_known, m_dt);
      txn_and_check($sformatf("rnd%0d", n), rws, qb, nb, ad, dt, int'($urandom_range(0, 2)),
                    m_ok, m_known, m_dt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
